// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg - shared types and defaults for the ARM_cpu memory arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, DONE)
//   owner_t : which pipeline port owns the memory (OWN_I=0 fetch, OWN_D=1 data)
//   DEF_*   : default address/data widths and memory latency
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant - combinational grant selection for mem_arbiter.
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin; when both ports request, the port that was not
//               served last wins. A single requester always wins.
//   undefined : fixed priority, data port over instruction port.
// Ports:
//   i_ireq        instruction port request
//   i_dreq        data port request
//   i_last_owner  port granted most recently
//   o_valid       some port is requesting
//   o_owner       port to grant (meaningful when o_valid)
module mem_arb_grant
  import arm_mem_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
  input  owner_t i_last_owner,
  output logic   o_valid,
  output owner_t o_owner
);

`ifndef ARB_RR_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic w_unused_last;
  assign w_unused_last = i_last_owner;
`endif

  always_comb begin
    o_valid = i_ireq | i_dreq;
    o_owner = OWN_D;
`ifdef ARB_RR_EN
    if (i_ireq && i_dreq) begin
      o_owner = (i_last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_dreq) begin
      o_owner = OWN_D;
    end else begin
      o_owner = OWN_I;
    end
`else
    // The memory stage holds the older instruction, so data wins ties.
    o_owner = i_dreq ? OWN_D : OWN_I;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter - shares one fixed-latency single-port memory between the
// ARM_cpu fetch stage (i_* port) and memory stage (d_* port).
// Optional feature macro: ARB_RR_EN (round-robin arbitration, see mem_arb_grant).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                fetch request (level) and address
//   i_rdata/i_ready/i_stall     fetched word, one-cycle done pulse, stall
//   d_req/d_we/d_addr/d_wdata   data request, write enable, address, store data
//   d_rdata/d_ready/d_stall     load word, one-cycle done pulse, stall
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//   dbg_state                   current FSM state for observation
// Handshake: a port holds x_req high until it sees the one-cycle x_ready
// pulse; x_stall = x_req & ~x_ready. Request/address/data are latched at
// grant and changes afterwards are ignored until the access completes.
// Timing: request seen in IDLE in cycle 0, BUSY in cycles 1..MEM_LAT,
// mem_we in cycle MEM_LAT (writes only), ready in cycle MEM_LAT+1 (DONE).
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  owner_t            r_owner;
  owner_t            r_last_owner;
  logic              r_we;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;

  logic              w_grant_valid;
  owner_t            w_grant_owner;
  logic              w_grant_we;

  mem_arb_grant u_grant (
    .i_ireq       (i_req),
    .i_dreq       (d_req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_grant_valid),
    .o_owner      (w_grant_owner)
  );

  // Fetches never write.
  assign w_grant_we = (w_grant_owner == OWN_D) & d_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= OWN_D;
      r_last_owner <= OWN_D;
      r_we         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_mem_we  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_owner;
            r_last_owner <= w_grant_owner;
            r_we         <= w_grant_we;
            r_mem_addr   <= (w_grant_owner == OWN_D) ? d_addr : i_addr;
            r_mem_wdata  <= (w_grant_owner == OWN_D) ? d_wdata : '0;
            r_cnt        <= CNT_INIT;
            r_mem_en     <= 1'b1;
            // With a one-cycle latency the first BUSY cycle is the final one.
            r_mem_we     <= (MEM_LAT == 1) & w_grant_we;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CNT_ONE;
            // Raise the write strobe for the upcoming final cycle only.
            r_mem_we <= (r_cnt == CNT_ONE) & r_we;
          end else begin
            if (!r_we) begin
              if (r_owner == OWN_D) r_d_rdata <= mem_rdata;
              else                  r_i_rdata <= mem_rdata;
            end
            if (r_owner == OWN_D) r_d_ready <= 1'b1;
            else                  r_i_ready <= 1'b1;
            r_mem_en <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Reset asserted during the final cycle must not let the write land.
  assign mem_we    = r_mem_we & ~rst;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign i_stall   = i_req & ~r_i_ready;
  assign d_stall   = d_req & ~r_d_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter - directed bench for mem_arbiter (MEM_LAT=4 main instance,
// MEM_LAT=1 second instance). Expected read responses are queued with the
// cycle they must appear in; a monitor pops them on every ready pulse.
module tb_mem_arbiter;
  import arm_mem_pkg::*;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  int          cyc;
  int          n_checks;
  int          n_fail;

  // main instance (MEM_LAT = 4)
  logic        i_req, i_ready, i_stall, d_req, d_we, d_ready, d_stall;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  // second instance (MEM_LAT = 1), fetch port only
  logic        i_req1, i_ready1, i_stall1, d_req1, d_we1, d_ready1, d_stall1;
  logic [31:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic        mem_en1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  state_t      dbg_state1;

  // scoreboard: {expected cycle, expected data}
  logic [63:0] exp_i_q[$];
  logic [63:0] exp_d_q[$];
  logic [63:0] exp_i1_q[$];
  logic [63:0] mon_e;

  logic [31:0] tb_mem [logic [31:0]];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1), .i_stall(i_stall1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .dbg_state(dbg_state1)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  // Unwritten locations read as {addr[15:0], 16'hC0DE}.
  always @(negedge clk) begin
    if (mem_en)
      mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : {mem_addr[15:0], 16'hC0DE};
    else
      mem_rdata <= 32'h0;
    mem_rdata1 <= mem_en1 ? {mem_addr1[15:0], 16'hC0DE} : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] = mem_wdata;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (i_ready) begin
      if (exp_i_q.size() == 0) check("i_ready_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = exp_i_q.pop_front();
        check("i_ready_cycle", 64'(cyc), {32'h0, mon_e[63:32]});
        check("i_rdata", {32'h0, i_rdata}, {32'h0, mon_e[31:0]});
      end
    end
    if (d_ready) begin
      if (exp_d_q.size() == 0) check("d_ready_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = exp_d_q.pop_front();
        check("d_ready_cycle", 64'(cyc), {32'h0, mon_e[63:32]});
        check("d_rdata", {32'h0, d_rdata}, {32'h0, mon_e[31:0]});
      end
    end
    if (i_ready1) begin
      if (exp_i1_q.size() == 0) check("i1_ready_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = exp_i1_q.pop_front();
        check("i1_ready_cycle", 64'(cyc), {32'h0, mon_e[63:32]});
        check("i1_rdata", {32'h0, i_rdata1}, {32'h0, mon_e[31:0]});
      end
    end
    if (d_ready1) check("d1_ready_unexpected", 64'd1, 64'd0);
  end

  // ---------------- driver: one access on the main instance ----------------
  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input string tag);
    int          t0;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    bit          done;
    logic        stall;
    logic        rdy;
    @(negedge clk);
    t0 = cyc;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      exp_d_q.push_back({32'(t0 + LAT + 1), exp_data});
    end else begin
      i_req = 1'b1; i_addr = addr;
      exp_i_q.push_back({32'(t0 + LAT + 1), exp_data});
    end
    we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0; done = 1'b0;
    for (int k = 0; k <= LAT + 20 && !done; k++) begin
      #1;
      stall = is_d ? d_stall : i_stall;
      rdy   = is_d ? d_ready : i_ready;
      if (k <= LAT + 1) check({tag, "_stall"}, 64'(stall), 64'(k <= LAT));
      if (mem_we) begin
        we_cnt++; we_cyc = cyc; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (rdy) begin
        done = 1'b1; d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    check({tag, "_mem_we_count"}, 64'(we_cnt), we ? 64'd1 : 64'd0);
    if (we) begin
      check({tag, "_mem_we_cycle"}, 64'(we_cyc), 64'(t0 + LAT));
      check({tag, "_mem_we_addr"}, {32'h0, we_addr}, {32'h0, addr});
      check({tag, "_mem_we_data"}, {32'h0, we_data}, {32'h0, wdata});
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int t0;
    int served;
    int n_i;
    int n_d;
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    mem_rdata = 0; mem_rdata1 = 0;
    tb_mem[32'h10] = 32'hE3A00005;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_i_rdata", {32'h0, i_rdata}, 64'h0);
    check("rst_d_rdata", {32'h0, d_rdata}, 64'h0);
    check("rst_ready", {62'h0, i_ready, d_ready}, 64'h0);
    check("rst_mem_en_we", {62'h0, mem_en, mem_we}, 64'h0);
    check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    rst = 1'b0;

    // single accesses
    do_access(1'b0, 1'b0, 32'h10,  32'h0,        32'hE3A00005, "ifetch");
    do_access(1'b1, 1'b0, 32'h80,  32'h0,        32'h0080C0DE, "dread");
    do_access(1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0080C0DE, "dwrite");
    do_access(1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, "dreadback");

    // both ports request together
    @(negedge clk);
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
`ifdef ARB_RR_EN
    exp_i_q.push_back({32'(t0 + 5), 32'h0020C0DE});
    exp_d_q.push_back({32'(t0 + 11), 32'h0030C0DE});
`else
    exp_d_q.push_back({32'(t0 + 5), 32'h0030C0DE});
    exp_i_q.push_back({32'(t0 + 11), 32'h0020C0DE});
`endif
    #1;
    check("both_stall", {62'h0, i_stall, d_stall}, 64'h3);
    for (int k = 0; k < 40 && (i_req || d_req); k++) begin
      if (d_ready) d_req = 1'b0;
      if (i_ready) i_req = 1'b0;
      if (i_req || d_req) begin
        @(negedge clk); #1;
      end
    end
    check("both_timeout", {62'h0, i_req, d_req}, 64'h0);

    // reset during BUSY cycle 2 of a write
    @(negedge clk);
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_mem_en", 64'(mem_en), 64'd1);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rstmid_state", 64'(dbg_state), 64'(IDLE));
    check("rstmid_mem", {30'h0, mem_en, mem_we, mem_addr}, 64'h0);
    check("rstmid_wdata", {32'h0, mem_wdata}, 64'h0);
    check("rstmid_rdata", {i_rdata, d_rdata}, 64'h0);
    check("rstmid_ready", {62'h0, i_ready, d_ready}, 64'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (mem_we || d_ready) check("rstmid_quiet", {62'h0, mem_we, d_ready}, 64'h0);
    end

    // reset during the final cycle of a write: the strobe must be gated
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h12345678;
    repeat (LAT) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstfin_mem_en", 64'(mem_en), 64'd1);
    check("rstfin_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rstfin_state", 64'(dbg_state), 64'(IDLE));
    check("rstfin_ready", 64'(d_ready), 64'd0);
    // location must still hold its default contents
    do_access(1'b1, 1'b0, 32'h500, 32'h0, 32'h0500C0DE, "rstfin_read");

    // both requests held high for 20 accesses
    @(negedge clk);
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
`ifdef ARB_RR_EN
    for (int j = 0; j < 10; j++) begin
      exp_i_q.push_back({32'(t0 + 5 + 12 * j), 32'h0700C0DE});
      exp_d_q.push_back({32'(t0 + 11 + 12 * j), 32'h0600C0DE});
    end
`else
    for (int j = 0; j < 20; j++) exp_d_q.push_back({32'(t0 + 5 + 6 * j), 32'h0600C0DE});
`endif
    served = 0; n_i = 0; n_d = 0;
    for (int k = 0; k < 200 && served < 20; k++) begin
      #1;
`ifndef ARB_RR_EN
      check("starve_i_stall", 64'(i_stall), 64'd1);
`endif
      if (i_ready || d_ready) begin
`ifdef ARB_RR_EN
        check("rr_order", {62'h0, i_ready, d_ready}, (served % 2 == 0) ? 64'h2 : 64'h1);
`else
        check("fixed_order", {62'h0, i_ready, d_ready}, 64'h1);
`endif
        if (i_ready) n_i++;
        if (d_ready) n_d++;
        served++;
        if (served == 20) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      if (served < 20) @(negedge clk);
    end
`ifdef ARB_RR_EN
    check("hold_counts", {32'(n_i), 32'(n_d)}, {32'd10, 32'd10});
`else
    check("hold_counts", {32'(n_i), 32'(n_d)}, {32'd0, 32'd20});
`endif

    // MEM_LAT=1: three back-to-back fetches
    @(negedge clk);
    t0 = cyc;
    i_req1 = 1'b1; i_addr1 = 32'h40;
    exp_i1_q.push_back({32'(t0 + 2), 32'h0040C0DE});
    exp_i1_q.push_back({32'(t0 + 5), 32'h0044C0DE});
    exp_i1_q.push_back({32'(t0 + 8), 32'h0048C0DE});
    served = 0;
    for (int k = 0; k < 40 && served < 3; k++) begin
      #1;
      if (k == 1) check("lat1_busy_state", 64'(dbg_state1), 64'(BUSY));
      if (i_ready1) begin
        served++;
        if (served == 1) i_addr1 = 32'h44;
        if (served == 2) i_addr1 = 32'h48;
        if (served == 3) i_req1 = 1'b0;
      end
      @(negedge clk);
    end
    check("lat1_served", 64'(served), 64'd3);

    repeat (4) @(negedge clk);
    check("exp_i_q_empty", 64'(exp_i_q.size()), 64'd0);
    check("exp_d_q_empty", 64'(exp_d_q.size()), 64'd0);
    check("exp_i1_q_empty", 64'(exp_i1_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
